// File: rtl/plot_arbiter.sv
// Round-robin arbiter granting one of three pixel sources bursts of plots
// into a single registered VGA adapter write port.
module plot_arbiter #(
    parameter int X_W       = 8,
    parameter int Y_W       = 7,
    parameter int C_W       = 3,
    parameter int MAX_BURST = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [2:0]       req,
    input  logic [2:0]       last,
    input  logic [3*X_W-1:0] x_in,
    input  logic [3*Y_W-1:0] y_in,
    input  logic [3*C_W-1:0] c_in,
    output logic [2:0]       grant,
    output logic [2:0]       ack,
    output logic [X_W-1:0]   vga_x,
    output logic [Y_W-1:0]   vga_y,
    output logic [C_W-1:0]   vga_colour,
    output logic             vga_plot,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BURST   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(MAX_BURST - 1);

    state_t         state_r, state_nx_s;
    logic [2:0]     grant_r, grant_nx_s;
    logic [1:0]     owner_r, owner_nx_s;
    logic [1:0]     last_owner_r, last_owner_nx_s;
    logic [7:0]     cnt_r, cnt_nx_s;
    logic [1:0]     pick_s;
    logic           ack_any_s;
    logic           owner_last_s;
    logic [X_W-1:0] x_sel_s;
    logic [Y_W-1:0] y_sel_s;
    logic [C_W-1:0] c_sel_s;

    // Search order starts just after the previous owner, so ties rotate.
    function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] lo);
        logic [1:0] p0, p1, p2;
        case (lo)
            2'd0:    begin p0 = 2'd1; p1 = 2'd2; p2 = 2'd0; end
            2'd1:    begin p0 = 2'd2; p1 = 2'd0; p2 = 2'd1; end
            default: begin p0 = 2'd0; p1 = 2'd1; p2 = 2'd2; end
        endcase
        if (r[p0]) begin
            return p0;
        end else if (r[p1]) begin
            return p1;
        end else begin
            return p2;
        end
    endfunction

    assign pick_s    = rr_pick(req, last_owner_r);
    assign ack       = ((state_r == BURST) && enable) ? (req & grant_r) : 3'b000;
    assign ack_any_s = |ack;
    assign grant     = grant_r;
    assign busy      = (state_r != IDLE);

    // Owner's end-of-burst flag and pixel fields.
    always_comb begin
        owner_last_s = 1'b0;
        x_sel_s      = '0;
        y_sel_s      = '0;
        c_sel_s      = '0;
        case (owner_r)
            2'd0: begin
                owner_last_s = last[0];
                x_sel_s = x_in[0*X_W +: X_W]; y_sel_s = y_in[0*Y_W +: Y_W]; c_sel_s = c_in[0*C_W +: C_W];
            end
            2'd1: begin
                owner_last_s = last[1];
                x_sel_s = x_in[1*X_W +: X_W]; y_sel_s = y_in[1*Y_W +: Y_W]; c_sel_s = c_in[1*C_W +: C_W];
            end
            2'd2: begin
                owner_last_s = last[2];
                x_sel_s = x_in[2*X_W +: X_W]; y_sel_s = y_in[2*Y_W +: Y_W]; c_sel_s = c_in[2*C_W +: C_W];
            end
            default: begin
                owner_last_s = 1'b0;
            end
        endcase
    end

    // Next-state logic; an enabled owner without an ack means it dropped req.
    always_comb begin
        state_nx_s      = state_r;
        grant_nx_s      = grant_r;
        owner_nx_s      = owner_r;
        last_owner_nx_s = last_owner_r;
        cnt_nx_s        = cnt_r;
        case (state_r)
            IDLE: begin
                if (enable && (req != 3'b000)) begin
                    owner_nx_s = pick_s;
                    grant_nx_s = 3'b001 << pick_s;
                    cnt_nx_s   = 8'd0;
                    state_nx_s = BURST;
                end else begin
                    grant_nx_s = 3'b000;
                end
            end
            BURST: begin
                if (enable) begin
                    if (ack_any_s) begin
                        cnt_nx_s = cnt_r + 8'd1;
                        if (owner_last_s || (cnt_r == CNT_LAST)) begin
                            state_nx_s = RELEASE;
                            grant_nx_s = 3'b000;
                        end else begin
                            state_nx_s = BURST;
                        end
                    end else begin
                        state_nx_s = RELEASE;
                        grant_nx_s = 3'b000;
                    end
                end else begin
                    state_nx_s = BURST;
                end
            end
            RELEASE: begin
                grant_nx_s      = 3'b000;
                last_owner_nx_s = owner_r;
                state_nx_s      = IDLE;
            end
            default: begin
                grant_nx_s = 3'b000;
                state_nx_s = IDLE;
            end
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            grant_r      <= 3'b000;
            owner_r      <= 2'd0;
            last_owner_r <= 2'd2;
            cnt_r        <= 8'd0;
        end else begin
            state_r      <= state_nx_s;
            grant_r      <= grant_nx_s;
            owner_r      <= owner_nx_s;
            last_owner_r <= last_owner_nx_s;
            cnt_r        <= cnt_nx_s;
        end
    end

    // VGA write port: capture the accepted pixel one edge after its ack.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
        end else if (ack_any_s) begin
            vga_x      <= x_sel_s;
            vga_y      <= y_sel_s;
            vga_colour <= c_sel_s;
            vga_plot   <= 1'b1;
        end else begin
            vga_plot   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_plot_arbiter.sv
// Scoreboard bench for plot_arbiter: sources queue pixels, accepted pixels are
// expected on the VGA port one edge later, bursts checked for owner and length.
module tb_plot_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [2:0]  req, last;
    logic [23:0] x_in;
    logic [20:0] y_in;
    logic [8:0]  c_in;
    logic [2:0]  grant, ack;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot, busy;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        logic       lst;
    } pix_t;

    typedef struct packed {
        logic [1:0] own;
        logic [8:0] len;
    } burst_t;

    pix_t        q0[$], q1[$], q2[$];
    logic [17:0] sb_q[$];
    burst_t      exp_q[$];
    int          n_vec = 0;
    int          n_mis = 0;
    int          cur_len, cur_exp_len, gap_cnt;
    bit          seen_burst, gap_chk, pause_chk;
    logic [2:0]  prev_grant;

    plot_arbiter #(.X_W(8), .Y_W(7), .C_W(3), .MAX_BURST(64)) dut (
        .clock(clock), .reset(reset), .enable(enable), .req(req), .last(last),
        .x_in(x_in), .y_in(y_in), .c_in(c_in), .grant(grant), .ack(ack),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .vga_plot(vga_plot), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int qsize(input int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic pix_t head(input int i);
        pix_t h;
        h = '0;
        case (i)
            0:       if (q0.size() > 0) h = q0[0];
            1:       if (q1.size() > 0) h = q1[0];
            default: if (q2.size() > 0) h = q2[0];
        endcase
        return h;
    endfunction

    task automatic pop(input int i);
        pix_t d;
        case (i)
            0:       d = q0.pop_front();
            1:       d = q1.pop_front();
            default: d = q2.pop_front();
        endcase
    endtask

    task automatic load(input int i, input int n, input logic [7:0] x0, input logic [6:0] y,
                        input logic [2:0] c, input bit rnd, input bit lst_end);
        pix_t p;
        for (int k = 0; k < n; k++) begin
            p.x   = rnd ? 8'($urandom) : x0 + 8'(k);
            p.y   = rnd ? 7'($urandom) : y;
            p.c   = rnd ? 3'($urandom) : c;
            p.lst = lst_end && (k == n - 1);
            case (i)
                0:       q0.push_back(p);
                1:       q1.push_back(p);
                default: q2.push_back(p);
            endcase
        end
    endtask

    task automatic expect_burst(input logic [1:0] own, input int len);
        burst_t b;
        b.own = own;
        b.len = 9'(len);
        exp_q.push_back(b);
    endtask

    task automatic drive_inputs();
        pix_t h;
        for (int i = 0; i < 3; i++) begin
            h = head(i);
            req[i]          = (qsize(i) != 0);
            last[i]         = h.lst;
            x_in[i*8 +: 8]  = h.x;
            y_in[i*7 +: 7]  = h.y;
            c_in[i*3 +: 3]  = h.c;
        end
    endtask

    task automatic step();
        pix_t        h;
        burst_t      b;
        logic [17:0] e;
        @(negedge clock);
        check_eq("ack_non_owner", 32'(ack & ~grant), 32'd0);
        if (pause_chk) begin
            check_eq("pause_ack", 32'(ack), 32'd0);
            check_eq("pause_grant", 32'(grant), 32'd1);
        end
        for (int i = 0; i < 3; i++) begin
            if (ack[i]) begin
                h = head(i);
                sb_q.push_back({h.x, h.y, h.c});
                pop(i);
                cur_len++;
            end
        end
        @(posedge clock);
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq("plot_pulse", 32'(vga_plot), 32'd1);
            check_eq("plot_pixel", 32'({vga_x, vga_y, vga_colour}), 32'(e));
        end else begin
            check_eq("plot_idle", 32'(vga_plot), 32'd0);
        end
        if (grant != 3'b000 && prev_grant == 3'b000) begin
            if (gap_chk && seen_burst) check_eq("burst_gap", 32'(gap_cnt), 32'd2);
            if (exp_q.size() > 0) begin
                b = exp_q.pop_front();
                check_eq("grant_owner", 32'(grant), 32'(3'b001 << b.own));
                cur_exp_len = int'(b.len);
            end else begin
                check_eq("unexpected_grant", 32'(grant), 32'd0);
            end
            cur_len    = 0;
            seen_burst = 1'b1;
            gap_cnt    = 0;
        end else if (grant == 3'b000 && prev_grant != 3'b000) begin
            check_eq("burst_len", 32'(cur_len), 32'(cur_exp_len));
            gap_cnt = 1;
        end else if (grant == 3'b000) begin
            gap_cnt++;
        end
        if (grant != 3'b000) check_eq("busy_in_burst", 32'(busy), 32'd1);
        prev_grant = grant;
        drive_inputs();
    endtask

    function automatic bit fin(input bit wait_src);
        bit f;
        f = (exp_q.size() == 0) && (grant == 3'b000);
        if (wait_src) f = f && !busy && (q0.size() == 0) && (q1.size() == 0) && (q2.size() == 0);
        return f;
    endfunction

    task automatic run_until(input int budget, input bit wait_src);
        int cyc;
        cyc = 0;
        while (!fin(wait_src) && cyc < budget) begin
            step();
            cyc++;
        end
        if (!fin(wait_src)) check_eq("timeout", 32'd1, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        enable = 1'b0;
        q0.delete(); q1.delete(); q2.delete();
        sb_q.delete(); exp_q.delete();
        prev_grant = 3'b000; seen_burst = 1'b0; gap_cnt = 0; cur_len = 0; pause_chk = 1'b0;
        drive_inputs();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        enable = 1'b1;
        @(posedge clock);
        #1;
    endtask

    initial begin
        gap_chk = 1'b0;
        do_reset();
        check_eq("rst_grant", 32'(grant), 32'd0);
        check_eq("rst_plot", 32'(vga_plot), 32'd0);
        check_eq("rst_xyc", 32'({vga_x, vga_y, vga_colour}), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);

        // Single requester 1, five pixels ending on last.
        expect_burst(2'd1, 5);
        load(1, 5, 8'd10, 7'd20, 3'b100, 1'b0, 1'b1);
        drive_inputs();
        run_until(50, 1'b1);

        // Requester 0 burst paused by enable for four cycles.
        expect_burst(2'd0, 10);
        load(0, 10, 8'd0, 7'd0, 3'd0, 1'b1, 1'b1);
        drive_inputs();
        repeat (3) step();
        enable = 1'b0;
        pause_chk = 1'b1;
        repeat (4) step();
        enable = 1'b1;
        pause_chk = 1'b0;
        run_until(50, 1'b1);

        // Requester 2 abandons after three pixels; 0 then 1 follow.
        seen_burst = 1'b0;
        gap_chk = 1'b1;
        expect_burst(2'd2, 3);
        load(2, 3, 8'd0, 7'd0, 3'd0, 1'b1, 1'b0);
        drive_inputs();
        repeat (2) step();
        expect_burst(2'd0, 2);
        expect_burst(2'd1, 2);
        load(0, 2, 8'd0, 7'd0, 3'd0, 1'b1, 1'b1);
        load(1, 2, 8'd0, 7'd0, 3'd0, 1'b1, 1'b1);
        drive_inputs();
        run_until(100, 1'b1);

        // All three requesting continuously: max-length bursts, rotating.
        do_reset();
        gap_chk = 1'b1;
        expect_burst(2'd0, 64);
        expect_burst(2'd1, 64);
        expect_burst(2'd2, 64);
        expect_burst(2'd0, 64);
        for (int i = 0; i < 3; i++) load(i, 200, 8'd0, 7'd0, 3'd0, 1'b1, 1'b0);
        drive_inputs();
        run_until(400, 1'b0);
        gap_chk = 1'b0;

        // Asynchronous reset mid-burst, then a 0/1 tie.
        do_reset();
        expect_burst(2'd0, 10);
        load(0, 10, 8'd0, 7'd0, 3'd0, 1'b1, 1'b1);
        drive_inputs();
        repeat (4) step();
        #3;
        reset = 1'b1;
        #1;
        check_eq("arst_grant", 32'(grant), 32'd0);
        check_eq("arst_plot", 32'(vga_plot), 32'd0);
        check_eq("arst_xyc", 32'({vga_x, vga_y, vga_colour}), 32'd0);
        check_eq("arst_ack", 32'(ack), 32'd0);
        check_eq("arst_busy", 32'(busy), 32'd0);
        do_reset();
        expect_burst(2'd0, 2);
        expect_burst(2'd1, 2);
        load(0, 2, 8'd0, 7'd0, 3'd0, 1'b1, 1'b1);
        load(1, 2, 8'd0, 7'd0, 3'd0, 1'b1, 1'b1);
        drive_inputs();
        run_until(60, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
